core_trace_buffer: RTL and testbench

Parametrised instruction-trace capture block that sits beside the processor core and replaces fixed-time simulation stops.
- Records PC, IR and flags {Cout,Z,N} into a circular buffer on every committed instruction.
- Stops on a PC-match trigger or a step limit, then asserts core_halt.
- Drains the captured history oldest-first over a valid/ready read port.
- Usable in simulation and on the board.

---
 rtl/core_trace_pkg.sv | 22 ++
 rtl/core_trace_buffer_if.sv | 43 ++++
 rtl/core_trace_ram.sv | 34 +++
 rtl/core_trace_buffer.sv | 154 +++++++++++++++
 tb/tb_core_trace_buffer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/core_trace_pkg.sv
// core_trace_pkg
// Shared definitions for the instruction-trace capture block:
//   - tr_state_e : capture FSM encoding, also driven out on the state port
//   - FLAG_*     : bit positions of {Cout,Z,N} inside the flags field
//   - entry_w()  : width of one stored trace entry {pc, ir, flags}
package core_trace_pkg;

  typedef enum logic [1:0] {
    TR_IDLE    = 2'd0,
    TR_CAPTURE = 2'd1,
    TR_DONE    = 2'd2
  } tr_state_e;

  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  function automatic int entry_w(input int pc_w, input int ir_w);
    return pc_w + ir_w + 3;
  endfunction

endpackage

// File: rtl/core_trace_buffer_if.sv
// core_trace_buffer_if
// Bundles the core-side capture inputs, trigger configuration and the
// valid/ready read port of the trace buffer.
//   master : the core / debug reader side (drives arm, steps, rd_ready)
//   slave  : the trace buffer itself
interface core_trace_buffer_if #(
  parameter int PC_W  = 8,
  parameter int IR_W  = 16,
  parameter int DEPTH = 32,
  parameter int LIM_W = 16
);
  import core_trace_pkg::*;

  localparam int ENT_W = entry_w(PC_W, IR_W);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             arm;
  logic             step_valid;
  logic [PC_W-1:0]  pc;
  logic [IR_W-1:0]  ir;
  logic [2:0]       flags;
  logic             trig_en;
  logic [PC_W-1:0]  trig_pc;
  logic [LIM_W-1:0] step_limit;
  logic             rd_ready;
  logic             rd_valid;
  logic [ENT_W-1:0] rd_data;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             core_halt;
  logic [1:0]       state;

  modport master (
    output arm, step_valid, pc, ir, flags, trig_en, trig_pc, step_limit, rd_ready,
    input  rd_valid, rd_data, count, overflow, core_halt, state
  );

  modport slave (
    input  arm, step_valid, pc, ir, flags, trig_en, trig_pc, step_limit, rd_ready,
    output rd_valid, rd_data, count, overflow, core_halt, state
  );

endinterface

// File: rtl/core_trace_ram.sv
// trace_ram
// DEPTH x WIDTH trace storage: one synchronous write port, one
// asynchronous read port. The array has no reset; validity of its
// contents is tracked by the pointers and count in the parent.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : mem[raddr], combinational
module trace_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 27,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/core_trace_buffer.sv
// core_trace_buffer
// Instruction-trace capture beside the processor core. While capturing,
// every committed instruction's {pc, ir, flags} goes into a circular
// buffer. A PC-match trigger or a step limit ends capture and freezes the
// core; the history is then drained oldest-first over a valid/ready port.
//
// Ports:
//   clock_50 : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   trc      : core_trace_buffer_if.slave
//              inputs  arm, step_valid, pc, ir, flags, trig_en, trig_pc,
//                      step_limit, rd_ready
//              outputs rd_valid, rd_data, count, overflow, core_halt, state
//
// state      | meaning
// -----------+-----------------------------------------------------------
// TR_IDLE    | after reset, steps ignored, waiting for arm
// TR_CAPTURE | recording committed instructions, watching stop condition
// TR_DONE    | core halted, buffer drains over the read port
module core_trace_buffer
  import core_trace_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int IR_W  = 16,
  parameter int DEPTH = 32,
  parameter int LIM_W = 16
) (
  input  logic                clock_50,
  input  logic                reset_n,
  core_trace_buffer_if.slave  trc
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int ENT_W = entry_w(PC_W, IR_W);

  tr_state_e        state_q, state_d;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [LIM_W-1:0] step_cnt, step_nxt;
  logic             overflow_q;
  logic             full;
  logic             stop_hit;
  logic             do_write;
  logic             do_pop;
  logic [ENT_W-1:0] rd_entry;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign step_nxt = step_cnt + LIM_W'(1);

  // step_nxt is the capture number of the step being written now. Once the
  // counter saturates at all-ones, step_nxt wraps to 0 and can never match a
  // non-zero limit, so an unlimited-length run cannot stop by accident.
  assign stop_hit = (trc.trig_en && (trc.pc == trc.trig_pc)) ||
                    ((trc.step_limit != '0) && (step_nxt == trc.step_limit));

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= TR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // arm overrides everything else in the same cycle: a coincident step
  // or pop is discarded because the clear below wins.
  always_comb begin
    state_d  = state_q;
    do_write = 1'b0;
    do_pop   = 1'b0;
    case (state_q)
      TR_IDLE: begin
        if (trc.arm) begin
          state_d = TR_CAPTURE;
        end
      end
      TR_CAPTURE: begin
        if (trc.arm) begin
          state_d = TR_CAPTURE;
        end else if (trc.step_valid) begin
          do_write = 1'b1;
          if (stop_hit) begin
            state_d = TR_DONE;
          end
        end
      end
      TR_DONE: begin
        if (trc.arm) begin
          state_d = TR_CAPTURE;
        end else if ((count_q != '0) && trc.rd_ready) begin
          do_pop = 1'b1;
        end
      end
      default: begin
        state_d = TR_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      step_cnt   <= '0;
      overflow_q <= 1'b0;
    end else if (trc.arm) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      step_cnt   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (step_cnt != '1) begin
          step_cnt <= step_nxt;
        end
        // Full buffer: the new entry lands on the oldest one, so the read
        // pointer moves along with the write pointer and count stays put.
        if (full) begin
          rd_ptr     <= rd_ptr + AW'(1);
          overflow_q <= 1'b1;
        end else begin
          count_q <= count_q + CNT_W'(1);
        end
      end
      if (do_pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_ram (
    .clk   (clock_50),
    .we    (do_write),
    .waddr (wr_ptr),
    .wdata ({trc.pc, trc.ir, trc.flags}),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign trc.rd_valid  = (state_q == TR_DONE) && (count_q != '0);
  assign trc.rd_data   = rd_entry;
  assign trc.count     = count_q;
  assign trc.overflow  = overflow_q;
  assign trc.core_halt = (state_q == TR_DONE);
  assign trc.state     = state_q;

endmodule

// File: tb/tb_core_trace_buffer.sv
// tb_core_trace_buffer
// Self-checking bench for core_trace_buffer. A reference queue models the
// circular buffer: entries are pushed as steps are driven while the model
// is capturing and popped as the DUT presents them on the read port.
module tb_core_trace_buffer;
  import core_trace_pkg::*;

  localparam int PC_W  = 8;
  localparam int IR_W  = 16;
  localparam int DEPTH = 32;
  localparam int LIM_W = 16;
  localparam int ENT_W = PC_W + IR_W + 3;

  typedef logic [ENT_W-1:0] ent_t;

  typedef struct {
    logic             te;
    logic [PC_W-1:0]  tp;
    logic [LIM_W-1:0] lim;
    int               n_drive;
    int               exp_count;
    logic             exp_ovf;
    int               exp_first;
    int               exp_last;
  } vec_t;

  logic clk;
  logic rst_n;

  core_trace_buffer_if #(.PC_W(PC_W), .IR_W(IR_W), .DEPTH(DEPTH), .LIM_W(LIM_W)) bus ();

  core_trace_buffer #(.PC_W(PC_W), .IR_W(IR_W), .DEPTH(DEPTH), .LIM_W(LIM_W)) dut (
    .clock_50 (clk),
    .reset_n  (rst_n),
    .trc      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_pass = 0;
  int   n_chk  = 0;
  ent_t sb[$];
  logic m_cap  = 1'b0;
  int   m_steps = 0;
  logic m_ovf  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Called at a negedge; returns at the next negedge with step_valid low.
  task automatic step_once(input logic [PC_W-1:0] p);
    ent_t e;
    logic [2:0] f;
    f = '0;
    f[FLAG_C] = p[2];
    f[FLAG_Z] = p[1];
    f[FLAG_N] = p[0];
    bus.step_valid = 1'b1;
    bus.pc         = p;
    bus.ir         = 16'h1000 + 16'(p);
    bus.flags      = f;
    e = {p, 16'h1000 + 16'(p), f};
    if (m_cap) begin
      sb.push_back(e);
      m_steps++;
      if (sb.size() > DEPTH) begin
        sb.delete(0);
        m_ovf = 1'b1;
      end
      if ((bus.trig_en && p == bus.trig_pc) ||
          (bus.step_limit != 0 && m_steps == int'(bus.step_limit)))
        m_cap = 1'b0;
    end
    @(negedge clk);
    bus.step_valid = 1'b0;
  endtask

  task automatic do_arm();
    bus.arm = 1'b1;
    sb.delete();
    m_steps = 0;
    m_ovf   = 1'b0;
    m_cap   = 1'b1;
    @(negedge clk);
    bus.arm = 1'b0;
  endtask

  task automatic drain(output int n, output int first_pc, output int last_pc);
    n = 0;
    first_pc = -1;
    last_pc  = -1;
    bus.rd_ready = 1'b1;
    for (int c = 0; c < DEPTH + 4; c++) begin
      if (!bus.rd_valid) break;
      if (sb.size() == 0) begin
        check("drain_extra_entry", 1, 0);
        break;
      end
      check("drain_data", bus.rd_data, sb[0]);
      sb.delete(0);
      if (n == 0) first_pc = int'(bus.rd_data[ENT_W-1 -: PC_W]);
      last_pc = int'(bus.rd_data[ENT_W-1 -: PC_W]);
      n++;
      @(negedge clk);
    end
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int n, fpc, lpc, xfers;

    vecs[0] = '{te:1'b1, tp:8'd4,  lim:16'd0,  n_drive:5,  exp_count:5,  exp_ovf:1'b0, exp_first:0, exp_last:4};
    vecs[1] = '{te:1'b1, tp:8'd40, lim:16'd0,  n_drive:41, exp_count:32, exp_ovf:1'b1, exp_first:9, exp_last:40};
    vecs[2] = '{te:1'b0, tp:8'd0,  lim:16'd3,  n_drive:6,  exp_count:3,  exp_ovf:1'b0, exp_first:0, exp_last:2};
    vecs[3] = '{te:1'b1, tp:8'd7,  lim:16'd10, n_drive:10, exp_count:8,  exp_ovf:1'b0, exp_first:0, exp_last:7};
    vecs[4] = '{te:1'b0, tp:8'd0,  lim:16'd1,  n_drive:3,  exp_count:1,  exp_ovf:1'b0, exp_first:0, exp_last:0};

    rst_n = 1'b0;
    bus.arm = 1'b0; bus.step_valid = 1'b0; bus.pc = '0; bus.ir = '0; bus.flags = '0;
    bus.trig_en = 1'b0; bus.trig_pc = '0; bus.step_limit = '0; bus.rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", bus.state, 0);
    check("reset_count", bus.count, 0);
    check("reset_rd_valid", bus.rd_valid, 0);
    check("reset_halt", bus.core_halt, 0);
    check("reset_overflow", bus.overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // IDLE ignores steps
    step_once(8'd3);
    check("idle_state", bus.state, 0);
    check("idle_count", bus.count, 0);

    foreach (vecs[v]) begin
      bus.trig_en    = vecs[v].te;
      bus.trig_pc    = vecs[v].tp;
      bus.step_limit = vecs[v].lim;
      do_arm();
      check("arm_state", bus.state, 1);
      check("arm_count", bus.count, 0);
      check("arm_overflow", bus.overflow, 0);
      check("arm_halt", bus.core_halt, 0);
      for (int i = 0; i < vecs[v].n_drive; i++) begin
        step_once(PC_W'(i));
        check("cap_state", bus.state, m_cap ? 1 : 2);
        check("cap_count", bus.count, sb.size());
        check("cap_rd_valid", bus.rd_valid, m_cap ? 0 : 1);
      end
      check("vec_state_done", bus.state, 2);
      check("vec_halt", bus.core_halt, 1);
      check("vec_count", bus.count, vecs[v].exp_count);
      check("vec_overflow", bus.overflow, vecs[v].exp_ovf);
      drain(n, fpc, lpc);
      check("vec_pops", n, vecs[v].exp_count);
      check("vec_first_pc", fpc, vecs[v].exp_first);
      check("vec_last_pc", lpc, vecs[v].exp_last);
      check("vec_empty_rd_valid", bus.rd_valid, 0);
      check("vec_empty_count", bus.count, 0);
      check("vec_empty_halt", bus.core_halt, 1);
    end

    // Backpressure: rd_ready toggles; rd_data must hold while not accepted
    bus.trig_en = 1'b1; bus.trig_pc = 8'd4; bus.step_limit = '0;
    do_arm();
    for (int i = 0; i < 5; i++) step_once(PC_W'(i));
    check("bp_count", bus.count, 5);
    xfers = 0;
    for (int c = 0; c < 30; c++) begin
      if (!bus.rd_valid) break;
      if (sb.size() == 0) begin
        check("bp_extra_entry", 1, 0);
        break;
      end
      check("bp_data", bus.rd_data, sb[0]);
      bus.rd_ready = c[0];
      @(negedge clk);
      if (bus.rd_ready) begin
        sb.delete(0);
        xfers++;
      end
    end
    bus.rd_ready = 1'b0;
    check("bp_xfers", xfers, 5);
    check("bp_rd_valid", bus.rd_valid, 0);

    // arm in DONE with unread entries and a coincident pop
    do_arm();
    for (int i = 0; i < 5; i++) step_once(PC_W'(i));
    bus.rd_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.rd_ready = 1'b0;
    check("rearm_pre_count", bus.count, 3);
    bus.rd_ready = 1'b1;
    do_arm();
    bus.rd_ready = 1'b0;
    check("rearm_count", bus.count, 0);
    check("rearm_state", bus.state, 1);
    check("rearm_overflow", bus.overflow, 0);
    check("rearm_halt", bus.core_halt, 0);
    check("rearm_rd_valid", bus.rd_valid, 0);

    // Asynchronous reset mid-capture
    bus.trig_en = 1'b0; bus.step_limit = '0;
    do_arm();
    for (int i = 0; i < 7; i++) step_once(PC_W'(i));
    check("rst_pre_count", bus.count, 7);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state", bus.state, 0);
    check("async_rst_count", bus.count, 0);
    check("async_rst_halt", bus.core_halt, 0);
    check("async_rst_overflow", bus.overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_cap = 1'b0;
    sb.delete();
    @(negedge clk);
    do_arm();
    step_once(8'd20);
    step_once(8'd21);
    check("post_rst_count", bus.count, 2);
    check("post_rst_state", bus.state, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
